mem_port_arbiter: RTL

//  Shares the single data-side memory port (read/write strobes, address, bidirectional data, ready/ack)

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory port between an I-cache (port 0) and a D-cache (port 1).
// Optional BUSY watchdog: define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TOUT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [WORD_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [WORD_SIZE-1:0] rdata0,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic                 err,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  inout  wire  [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_input_ready,
  input  logic                 mem_ack_output
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

  state_t               state, state_n;
  logic                 rr_ptr, rr_n, port_q, port_n, armed, armed_n, we_q, we_n;
  logic [WORD_SIZE-1:0] wdata_q, wdata_n, addr_n, rdata0_n, rdata1_n;
  logic                 gnt0_n, gnt1_n, done0_n, done1_n, mem_read_n, mem_write_n;
  logic                 sel_c, sel_we_c, complete_c, timeout_c, finish_c;

  // Watchdog counter must be able to reach TIMEOUT_CYCLES-1.
  if (TOUT_W == 0 || TIMEOUT_CYCLES == 0 || ((TIMEOUT_CYCLES - 1) >> TOUT_W) != 0) begin : g_bad_cfg
    $error("mem_port_arbiter: TOUT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef ARB_TIMEOUT_EN
  logic [TOUT_W-1:0] tout_q, tout_n;
  logic              err_n;
  assign timeout_c = (tout_q == TOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  assign sel_c      = (req0 && req1) ? rr_ptr : req1;
  assign sel_we_c   = sel_c ? we1 : we0;
  // Memory ready/ack are stale until it has seen our strobe, hence the armed qualifier.
  assign complete_c = armed && (we_q ? mem_ack_output : mem_input_ready);
  assign finish_c   = complete_c || timeout_c;

  assign mem_data = mem_write ? wdata_q : {WORD_SIZE{1'bz}};

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      port_q      <= 1'b0;
      armed       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_address <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tout_q      <= '0;
      err         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_n;
      port_q      <= port_n;
      armed       <= armed_n;
      we_q        <= we_n;
      wdata_q     <= wdata_n;
      mem_address <= addr_n;
      rdata0      <= rdata0_n;
      rdata1      <= rdata1_n;
      gnt0        <= gnt0_n;
      gnt1        <= gnt1_n;
      done0       <= done0_n;
      done1       <= done1_n;
      mem_read    <= mem_read_n;
      mem_write   <= mem_write_n;
`ifdef ARB_TIMEOUT_EN
      tout_q      <= tout_n;
      err         <= err_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req0 || req1) state_n = BUSY;
      BUSY:    if (finish_c) state_n = RELEASE;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    gnt0_n      = gnt0;
    gnt1_n      = gnt1;
    done0_n     = 1'b0;
    done1_n     = 1'b0;
    mem_read_n  = mem_read;
    mem_write_n = mem_write;
    addr_n      = mem_address;
    rdata0_n    = rdata0;
    rdata1_n    = rdata1;
    rr_n        = rr_ptr;
    port_n      = port_q;
    armed_n     = armed;
    we_n        = we_q;
    wdata_n     = wdata_q;
`ifdef ARB_TIMEOUT_EN
    err_n       = 1'b0;
    tout_n      = tout_q;
`endif
    case (state)
      IDLE: if (req0 || req1) begin
        port_n      = sel_c;
        we_n        = sel_we_c;
        addr_n      = sel_c ? addr1 : addr0;
        wdata_n     = sel_c ? wdata1 : wdata0;
        gnt0_n      = ~sel_c;
        gnt1_n      = sel_c;
        mem_read_n  = ~sel_we_c;
        mem_write_n = sel_we_c;
        armed_n     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tout_n      = '0;
`endif
      end
      BUSY: begin
        armed_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
        tout_n  = tout_q + TOUT_W'(1);
`endif
        if (finish_c) begin
          gnt0_n      = 1'b0;
          gnt1_n      = 1'b0;
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
          rr_n        = ~port_q;
          done0_n     = ~port_q;
          done1_n     = port_q;
          if (complete_c && !we_q) begin
            if (port_q) rdata1_n = mem_data;
            else        rdata0_n = mem_data;
          end
`ifdef ARB_TIMEOUT_EN
          err_n = ~complete_c;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule
